mq_cu_sched: RTL

// Code-unit scheduler for the MQ coder. Takes renormalisation jobs (shift count, C-add select, coder-reset, flush) from the
// IU->CU pipeline register and drives the C register: add, CT-bounded shifts, byte-out handshakes and the MQ FLUSH sequence.

---
 rtl/mq_cu_sched_pkg.sv | 25 ++
 rtl/mq_cu_sched_if.sv | 36 +++
 rtl/mq_cu_sched.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/mq_cu_sched_pkg.sv
// Shared definitions for the MQ coder code unit (CU) and the byte-out unit.
//   state_e       : CU scheduler states.
//   CT_INIT_DFLT  : CT value after reset or a coder-reset job.
//   CT_RELOAD     : CT reload after a normal byte-out.
//   CT_RELOAD_FF  : CT reload after a 0xFF byte. Bit stuffing leaves room for only 7 bits.
package mq_cu_sched_pkg;

  typedef enum logic [3:0] {
    IDLE,
    ADD,
    SHIFT,
    BYTEOUT,
    F_SET,
    F_SH1,
    F_BO1,
    F_SH2,
    F_BO2,
    DONE
  } state_e;

  localparam int CT_INIT_DFLT = 12;
  localparam int CT_RELOAD    = 8;
  localparam int CT_RELOAD_FF = 7;

endpackage

// File: rtl/mq_cu_sched_if.sv
// Bundle between the IU->CU pipeline register, the byte-out unit and the CU scheduler.
//   Job in      : in_valid, in_ready, lz, csel, rst_cu, flush_cu
//   Byte-out    : b_is_ff, bo_ack (byte-out unit -> CU), bo_req (CU -> byte-out unit)
//   C register  : c_add, setbits, shift_en, shift_amt
//   Status      : ct, done
// The master modport is the job/byte-out side. The slave modport is the scheduler.
interface mq_cu_sched_if #(
  parameter int LZW = 4,
  parameter int CTW = 4
) ();
  logic           in_valid;
  logic           in_ready;
  logic [LZW-1:0] lz;
  logic           csel;
  logic           rst_cu;
  logic           flush_cu;
  logic           b_is_ff;
  logic           bo_ack;
  logic           c_add;
  logic           setbits;
  logic           shift_en;
  logic [LZW-1:0] shift_amt;
  logic           bo_req;
  logic [CTW-1:0] ct;
  logic           done;

  modport master (
    output in_valid, lz, csel, rst_cu, flush_cu, b_is_ff, bo_ack,
    input  in_ready, c_add, setbits, shift_en, shift_amt, bo_req, ct, done
  );

  modport slave (
    input  in_valid, lz, csel, rst_cu, flush_cu, b_is_ff, bo_ack,
    output in_ready, c_add, setbits, shift_en, shift_amt, bo_req, ct, done
  );
endinterface

// File: rtl/mq_cu_sched.sv
// MQ coder code-unit scheduler.
// The scheduler takes renormalisation jobs from the IU->CU register. For each job it
// sequences the C add, the CT-bounded shifts and the byte-out handshakes. It also runs
// the FLUSH sequence. The CT counter lives here.
//   clk  : clock
//   rst  : synchronous reset, active-low
//   bus  : mq_cu_sched_if.slave. It carries the job handshake, the byte-out handshake,
//          the C-register controls, ct and done.
// All outputs decode from the registered state, so every output is a Moore output.
module mq_cu_sched
  import mq_cu_sched_pkg::*;
#(
  parameter int LZW     = 4,
  parameter int CTW     = 4,
  parameter int CT_INIT = CT_INIT_DFLT
) (
  input  logic            clk,
  input  logic            rst,
  mq_cu_sched_if.slave    bus
);

  localparam int AW = (LZW > CTW) ? LZW : CTW;
  localparam logic [CTW-1:0] CT_INIT_V   = CTW'(CT_INIT);
  localparam logic [CTW-1:0] RELOAD_V    = CTW'(CT_RELOAD);
  localparam logic [CTW-1:0] RELOAD_FF_V = CTW'(CT_RELOAD_FF);

  // The shift distance is capped by CT, so a single shift never crosses a byte boundary.
  function automatic logic [AW-1:0] min_amt(input logic [LZW-1:0] r, input logic [CTW-1:0] c);
    logic [AW-1:0] re;
    logic [AW-1:0] ce;
    re = AW'(r);
    ce = AW'(c);
    return (re < ce) ? re : ce;
  endfunction

  state_e         state_q, state_d;
  logic [CTW-1:0] ct_q, ct_d;
  logic [LZW-1:0] rem_q, rem_d;
  logic           csel_q, csel_d;

  logic           in_ready;
  logic           c_add;
  logic           setbits;
  logic           shift_en;
  logic [LZW-1:0] shift_amt;
  logic           bo_req;
  logic           done;
  logic [AW-1:0]  amt;
  logic [CTW-1:0] reload;

  always_comb begin
    state_d   = state_q;
    ct_d      = ct_q;
    rem_d     = rem_q;
    csel_d    = csel_q;
    in_ready  = 1'b0;
    c_add     = 1'b0;
    setbits   = 1'b0;
    shift_en  = 1'b0;
    shift_amt = '0;
    bo_req    = 1'b0;
    done      = 1'b0;
    amt       = min_amt(rem_q, ct_q);
    reload    = bus.b_is_ff ? RELOAD_FF_V : RELOAD_V;

    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (bus.in_valid) begin
          if (bus.rst_cu) begin
            ct_d  = CT_INIT_V;
            rem_d = '0;
          end else if (bus.flush_cu) begin
            rem_d   = '0;
            state_d = F_SET;
          end else begin
            rem_d   = bus.lz;
            csel_d  = bus.csel;
            state_d = ADD;
          end
        end
      end
      ADD: begin
        c_add   = csel_q;
        state_d = (rem_q == '0) ? IDLE : SHIFT;
      end
      SHIFT: begin
        shift_en  = 1'b1;
        shift_amt = LZW'(amt);
        ct_d      = ct_q - CTW'(amt);
        rem_d     = rem_q - LZW'(amt);
        // An emptied CT takes priority: the byte goes out before any remaining shift.
        if (ct_d == '0)        state_d = BYTEOUT;
        else if (rem_d == '0)  state_d = IDLE;
        else                   state_d = SHIFT;
      end
      BYTEOUT: begin
        bo_req = 1'b1;
        if (bus.bo_ack) begin
          ct_d    = reload;
          state_d = (rem_q != '0) ? SHIFT : IDLE;
        end
      end
      F_SET: begin
        setbits = 1'b1;
        state_d = F_SH1;
      end
      F_SH1, F_SH2: begin
        // The flush pushes out every bit CT still holds.
        shift_en  = 1'b1;
        shift_amt = LZW'(ct_q);
        ct_d      = '0;
        state_d   = (state_q == F_SH1) ? F_BO1 : F_BO2;
      end
      F_BO1, F_BO2: begin
        bo_req = 1'b1;
        if (bus.bo_ack) begin
          ct_d    = reload;
          state_d = (state_q == F_BO1) ? F_SH2 : DONE;
        end
      end
      DONE: begin
        done    = 1'b1;
        ct_d    = CT_INIT_V;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      ct_q    <= CT_INIT_V;
      rem_q   <= '0;
      csel_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ct_q    <= ct_d;
      rem_q   <= rem_d;
      csel_q  <= csel_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.c_add     = c_add;
  assign bus.setbits   = setbits;
  assign bus.shift_en  = shift_en;
  assign bus.shift_amt = shift_amt;
  assign bus.bo_req    = bo_req;
  assign bus.ct        = ct_q;
  assign bus.done      = done;

endmodule
